// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM states and RGB565 field layout for the camera capture path
package cam_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, ACTIVE = 2'd2} state_t;
  localparam int R_LSB = 11;
  localparam int R_W   = 5;
  localparam int G_LSB = 5;
  localparam int G_W   = 6;
  localparam int B_LSB = 0;
  localparam int B_W   = 5;
  function automatic logic [15:0] rgb565(input logic [R_W-1:0] r, input logic [G_W-1:0] g, input logic [B_W-1:0] b);
    logic [15:0] p;
    p = '0;
    p[R_LSB +: R_W] = r;
    p[G_LSB +: G_W] = g;
    p[B_LSB +: B_W] = b;
    return p;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: async-clear multi-flop synchronizer chain for a bus of asynchronous inputs
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] chain_q [STAGES];
  // shift every bit through STAGES flops; reset clears the whole chain
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/cam_dvp_capture.sv
// cam_dvp_capture: oversampled DVP byte capture, RGB565 pairing and valid/ready pixel output
module cam_dvp_capture
  import cam_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LINE_PIX    = 640,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             capture_en,
  input  logic             cam_pclk,
  input  logic             cam_vsync,
  input  logic             cam_hsync,
  input  logic [7:0]       cam_data,
  input  logic             img_ready,
  output logic             img_valid,
  output logic [15:0]      img_data,
  output logic             img_sync,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             line_err
);
  logic             pclk_s, vs_s, hs_s;
  logic [7:0]       data_s;
  logic             pclk_prev_q, vs_prev_q, hs_prev_q;
  state_t           state_q;
  logic             phase_q, first_q, err_q;
  logic [7:0]       hi_q;
  logic [15:0]      pix_cnt_q;
  logic [CNT_W-1:0] frame_q, drop_q, drop_d;
  logic             valid_q, valid_d, sync_q;
  logic [15:0]      data_q;
  logic             pclk_rise, vs_rise, vs_fall, hs_fall, form, load;
  sync_ff #(.WIDTH(11), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     ({cam_pclk, cam_vsync, cam_hsync, cam_data}),
    .q_o     ({pclk_s, vs_s, hs_s, data_s})
  );
  assign pclk_rise = pclk_s & ~pclk_prev_q;
  assign vs_rise   = vs_s & ~vs_prev_q;
  assign vs_fall   = ~vs_s & vs_prev_q;
  assign hs_fall   = ~hs_s & hs_prev_q;
  // a frame-ending vsync rise wins over a byte arriving in the same cycle
  assign form      = (state_q == ACTIVE) & ~vs_rise & pclk_rise & hs_s & phase_q;
  assign load      = form & (~valid_q | img_ready);
  // output slot and drop counter next state
  always_comb begin
    valid_d = load | (valid_q & ~img_ready);
    drop_d  = (form & ~load & (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
  end
  // edge history, frame FSM, byte pairing, line checks and frame counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pclk_prev_q <= 1'b0;
      vs_prev_q   <= 1'b0;
      hs_prev_q   <= 1'b0;
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      hi_q        <= '0;
      pix_cnt_q   <= '0;
      frame_q     <= '0;
    end else begin
      pclk_prev_q <= pclk_s;
      vs_prev_q   <= vs_s;
      hs_prev_q   <= hs_s;
      case (state_q)
        IDLE: if (vs_rise) state_q <= WAIT_VS;
        WAIT_VS: if (vs_fall && capture_en) begin
          state_q   <= ACTIVE;
          phase_q   <= 1'b0;
          pix_cnt_q <= '0;
          first_q   <= 1'b1;
        end
        ACTIVE: if (vs_rise) begin
          state_q   <= capture_en ? WAIT_VS : IDLE;
          frame_q   <= frame_q + 1'b1;
          phase_q   <= 1'b0;
          pix_cnt_q <= '0;
        end else if (hs_fall) begin
          if (phase_q || pix_cnt_q != 16'(LINE_PIX)) err_q <= 1'b1;
          phase_q   <= 1'b0;
          pix_cnt_q <= '0;
        end else if (pclk_rise && hs_s) begin
          if (!phase_q) hi_q <= data_s;
          else pix_cnt_q <= pix_cnt_q + 16'd1;
          phase_q <= ~phase_q;
        end
        default: state_q <= IDLE;
      endcase
      if (load) first_q <= 1'b0;
    end
  // single-entry output register; a held pixel is never overwritten
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      drop_q  <= drop_d;
      if (load) begin
        data_q <= rgb565(hi_q[7:3], {hi_q[2:0], data_s[7:5]}, data_s[4:0]);
        sync_q <= first_q;
      end
    end
  assign img_valid   = valid_q;
  assign img_data    = data_q;
  assign img_sync    = sync_q;
  assign frame_count = frame_q;
  assign drop_count  = drop_q;
  assign line_err    = err_q;
endmodule

// File: tb/tb_cam_dvp_capture.sv
// tb_cam_dvp_capture: directed table-driven checks of DVP capture, backpressure and frame control
module tb_cam_dvp_capture;
  logic        clk = 1'b0, reset_n = 1'b0, capture_en = 1'b0, img_ready = 1'b1;
  logic        cam_pclk = 1'b0, cam_vsync = 1'b0, cam_hsync = 1'b0;
  logic [7:0]  cam_data = '0;
  logic        img_valid, img_sync, line_err;
  logic [15:0] img_data, frame_count, drop_count;
  int          checks = 0, failures = 0;
  logic [16:0] got_q [$];
  logic [7:0]  lb [$];
  logic        valid_seen = 1'b0;
  logic [16:0] item;
  typedef struct {logic [7:0] hi; logic [7:0] lo; logic [15:0] exp; logic sync;} vec_t;
  vec_t tab [8];
  always #5 clk = ~clk;
  cam_dvp_capture #(.SYNC_STAGES(2), .LINE_PIX(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .capture_en  (capture_en),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_hsync   (cam_hsync),
    .cam_data    (cam_data),
    .img_ready   (img_ready),
    .img_valid   (img_valid),
    .img_data    (img_data),
    .img_sync    (img_sync),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .line_err    (line_err)
  );
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (img_valid) valid_seen = 1'b1;
      if (img_valid && img_ready) got_q.push_back({img_sync, img_data});
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [16:0] pop();
    return (got_q.size() > 0) ? got_q.pop_front() : 17'h1FFFF;
  endfunction
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    wait_clk(4);
    cam_pclk = 1'b1;
    wait_clk(4);
  endtask
  task automatic send_line();
    cam_hsync = 1'b1;
    wait_clk(2);
    foreach (lb[i]) send_byte(lb[i]);
    cam_hsync = 1'b0;
    wait_clk(8);
  endtask
  task automatic vs_set(input logic v);
    cam_vsync = v;
    wait_clk(10);
  endtask
  initial begin
    tab[0] = '{8'hF8, 8'h00, 16'hF800, 1'b1};
    tab[1] = '{8'h07, 8'hE0, 16'h07E0, 1'b0};
    tab[2] = '{8'h00, 8'h1F, 16'h001F, 1'b0};
    tab[3] = '{8'hFF, 8'hFF, 16'hFFFF, 1'b0};
    tab[4] = '{8'h12, 8'h34, 16'h1234, 1'b0};
    tab[5] = '{8'h56, 8'h78, 16'h5678, 1'b0};
    tab[6] = '{8'h9A, 8'hBC, 16'h9ABC, 1'b0};
    tab[7] = '{8'hDE, 8'hF0, 16'hDEF0, 1'b0};
    wait_clk(3);
    check("reset_outputs", {img_valid, img_sync, img_data, line_err}, 32'd0);
    check("reset_counters", {frame_count, drop_count}, 32'd0);
    reset_n = 1'b1;
    capture_en = 1'b1;
    wait_clk(3);
    vs_set(1'b1);
    vs_set(1'b0);
    for (int l = 0; l < 2; l++) begin
      lb = {};
      for (int k = 0; k < 4; k++) begin
        lb.push_back(tab[l*4+k].hi);
        lb.push_back(tab[l*4+k].lo);
      end
      send_line();
    end
    check("t1_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      item = pop();
      check($sformatf("t1_pix%0d", i), {15'd0, item}, {15'd0, tab[i].sync, tab[i].exp});
    end
    check("t1_line_err", line_err, 0);
    vs_set(1'b1);
    check("t1_frame_count", frame_count, 1);
    vs_set(1'b0);
    img_ready = 1'b0;
    lb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    send_line();
    check("t2_held", {img_valid, img_sync, img_data}, {14'd0, 1'b1, 1'b1, 16'hA1B2});
    check("t2_drop", drop_count, 3);
    check("t2_no_hs", got_q.size(), 0);
    img_ready = 1'b1;
    wait_clk(5);
    check("t2_one_hs", got_q.size(), 1);
    item = pop();
    check("t2_hs_pix", {15'd0, item}, {15'd0, 1'b1, 16'hA1B2});
    check("t2_valid_low", img_valid, 0);
    cam_hsync = 1'b1;
    wait_clk(2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    vs_set(1'b1);
    cam_hsync = 1'b0;
    wait_clk(10);
    check("t5_count", got_q.size(), 1);
    item = pop();
    check("t5_pix", {15'd0, item}, {15'd0, 1'b0, 16'h1122});
    check("t5_line_err", line_err, 0);
    check("t5_frame_count", frame_count, 2);
    vs_set(1'b0);
    lb = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
    send_line();
    check("t5_next_count", got_q.size(), 4);
    item = pop();
    check("t5_next_first", {15'd0, item}, {15'd0, 1'b1, 16'h4455});
    got_q.delete();
    lb = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    send_line();
    check("t3_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      item = pop();
      check($sformatf("t3_pix%0d", i), {15'd0, item}, {15'd0, 1'b0, 16'hC1C2 + 16'(i) * 16'h0202});
    end
    check("t3_line_err", line_err, 1);
    vs_set(1'b1);
    check("t4_frame_count", frame_count, 3);
    capture_en = 1'b0;
    vs_set(1'b0);
    valid_seen = 1'b0;
    lb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_line();
    check("t4_no_valid", valid_seen, 0);
    capture_en = 1'b1;
    vs_set(1'b1);
    check("t4_skip_not_counted", frame_count, 3);
    vs_set(1'b0);
    lb = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
    send_line();
    check("t4_count", got_q.size(), 4);
    item = pop();
    check("t4_first", {15'd0, item}, {15'd0, 1'b1, 16'hD0D1});
    check("t3_err_sticky", line_err, 1);
    got_q.delete();
    img_ready = 1'b0;
    cam_hsync = 1'b1;
    wait_clk(2);
    send_byte(8'hE1);
    send_byte(8'hE2);
    check("t6_valid_before", {img_valid, img_data}, {15'd0, 1'b1, 16'hE1E2});
    cam_data = 8'hE3;
    cam_pclk = 1'b0;
    wait_clk(2);
    reset_n = 1'b0;
    #1;
    check("t6_reset_outputs", {img_valid, img_sync, img_data, line_err}, 32'd0);
    check("t6_reset_counters", {frame_count, drop_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    img_ready = 1'b1;
    valid_seen = 1'b0;
    cam_pclk = 1'b1;
    wait_clk(4);
    send_byte(8'hE4);
    cam_hsync = 1'b0;
    wait_clk(8);
    lb = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    send_line();
    vs_set(1'b1);
    check("t6_no_valid", valid_seen, 0);
    vs_set(1'b0);
    lb = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7};
    send_line();
    check("t6_count", got_q.size(), 4);
    item = pop();
    check("t6_first", {15'd0, item}, {15'd0, 1'b1, 16'hF0F1});
    check("t6_counters", {frame_count, drop_count}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
